// File: rtl/ws2812_bit_ctl.sv
// ws2812_bit_ctl: pixel-to-bit sequencer feeding a WS2812 bit waveform generator.
// Accepts GRB pixel words, shifts them out MSB first as one request per bit,
// waits for the generator's done pulse per bit, then holds a programmable
// latch gap before reporting frame completion.
//
// Handshakes:
//   pixel input : a word is taken on any rising clk_in edge where
//                 pix_valid_in and pix_ready_out are both high; pix_ready_out
//                 does not depend on pix_valid_in.
//   bit output  : bit_rdy_out is a one-cycle request; bit_data_out is valid in
//                 that cycle and is held until the generator answers with
//                 bit_done_in. A done pulse in the request cycle itself is
//                 stale and ignored.
module ws2812_bit_ctl #(
  parameter int PIXEL_BITS    = 24,
  parameter int PIX_CNT_WIDTH = 8,
  parameter int RST_CNT_WIDTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_start_in,
  input  logic [PIX_CNT_WIDTH-1:0] pixel_num_in,
  input  logic [RST_CNT_WIDTH-1:0] rst_cnt_in,
  input  logic                     pix_valid_in,
  input  logic [PIXEL_BITS-1:0]    pix_data_in,
  output logic                     pix_ready_out,
  input  logic                     bit_done_in,
  output logic                     bit_rdy_out,
  output logic                     bit_data_out,
  output logic                     frame_busy_out,
  output logic                     frame_done_out
);

  localparam int IDX_W = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(PIXEL_BITS - 1);
  localparam logic [IDX_W-1:0]         IDX_ZERO = '0;
  localparam logic [IDX_W-1:0]         IDX_ONE  = IDX_W'(1);
  localparam logic [PIX_CNT_WIDTH-1:0] PIX_ZERO = '0;
  localparam logic [PIX_CNT_WIDTH-1:0] PIX_ONE  = PIX_CNT_WIDTH'(1);
  localparam logic [RST_CNT_WIDTH-1:0] GAP_ONE  = RST_CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LATCH = 3'd4
  } state_e;

  state_e                   state_q,    state_d;
  logic [PIXEL_BITS-1:0]    shift_q,    shift_d;
  logic [IDX_W-1:0]         bit_idx_q,  bit_idx_d;
  logic [PIX_CNT_WIDTH-1:0] pix_left_q, pix_left_d;
  logic [RST_CNT_WIDTH-1:0] gap_cnt_q,  gap_cnt_d;
  logic                     bit_data_q, bit_data_d;
  logic                     busy_q,     busy_d;
  logic                     done_q,     done_d;

  // Next-state logic: sequencing of pixels, bits and the latch gap.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    pix_left_d = pix_left_q;
    gap_cnt_d  = gap_cnt_q;
    bit_data_d = bit_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start_in) begin
          busy_d = 1'b1;
          if (pixel_num_in != PIX_ZERO) begin
            pix_left_d = pixel_num_in;
            state_d    = ST_LOAD;
          end else begin
            // Empty frame: only the latch gap is produced.
            gap_cnt_d = rst_cnt_in;
            state_d   = ST_LATCH;
          end
        end
      end

      ST_LOAD: begin
        // pix_ready_out is high throughout this state, so valid alone completes the handshake.
        if (pix_valid_in) begin
          shift_d    = pix_data_in;
          bit_idx_d  = LAST_IDX;
          bit_data_d = pix_data_in[PIXEL_BITS-1];
          state_d    = ST_SEND;
        end
      end

      ST_SEND: begin
        // Single request cycle; any done pulse seen here belongs to the previous bit.
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bit_done_in) begin
          if (bit_idx_q != IDX_ZERO) begin
            shift_d    = shift_q << 1;
            bit_idx_d  = bit_idx_q - IDX_ONE;
            bit_data_d = shift_d[PIXEL_BITS-1];
            state_d    = ST_SEND;
          end else if (pix_left_q > PIX_ONE) begin
            pix_left_d = pix_left_q - PIX_ONE;
            state_d    = ST_LOAD;
          end else begin
            gap_cnt_d = rst_cnt_in;
            state_d   = ST_LATCH;
          end
        end
      end

      ST_LATCH: begin
        // A loaded count of 0 or 1 both give a single gap cycle.
        if (gap_cnt_q <= GAP_ONE) begin
          gap_cnt_d = '0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      pix_left_q <= '0;
      gap_cnt_q  <= '0;
      bit_data_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      pix_left_q <= pix_left_d;
      gap_cnt_q  <= gap_cnt_d;
      bit_data_q <= bit_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign pix_ready_out  = (state_q == ST_LOAD);
  assign bit_rdy_out    = (state_q == ST_SEND);
  assign bit_data_out   = bit_data_q;
  assign frame_busy_out = busy_q;
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_ws2812_bit_ctl.sv
// tb_ws2812_bit_ctl: randomized frames against a queue-based reference of the
// expected bit stream and frame-completion times, with a generator model
// answering each bit request after a random delay.
module tb_ws2812_bit_ctl;

  localparam int PB = 24;
  localparam int PW = 8;
  localparam int RW = 16;

  // ---------------- clock / reset ----------------
  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          frame_start_in = 1'b0;
  logic [PW-1:0] pixel_num_in = '0;
  logic [RW-1:0] rst_cnt_in = '0;
  logic          pix_valid_in = 1'b0;
  logic [PB-1:0] pix_data_in = '0;
  logic          pix_ready_out;
  logic          bit_done_in = 1'b0;
  logic          bit_rdy_out;
  logic          bit_data_out;
  logic          frame_busy_out;
  logic          frame_done_out;

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  ws2812_bit_ctl #(.PIXEL_BITS(PB), .PIX_CNT_WIDTH(PW), .RST_CNT_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .pixel_num_in(pixel_num_in), .rst_cnt_in(rst_cnt_in),
    .pix_valid_in(pix_valid_in), .pix_data_in(pix_data_in),
    .pix_ready_out(pix_ready_out), .bit_done_in(bit_done_in),
    .bit_rdy_out(bit_rdy_out), .bit_data_out(bit_data_out),
    .frame_busy_out(frame_busy_out), .frame_done_out(frame_done_out)
  );

  // ---------------- scoreboard state ----------------
  logic [0:0]    exp_q[$];        // expected bit stream, MSB of each pixel first
  int            exp_done_q[$];   // expected cycle of each frame_done_out
  logic [PB-1:0] data_q[$];       // directed pixel words (random when empty)
  int  n_checks = 0;
  int  n_pass = 0;
  int  bits_remaining = 0;
  int  bits_seen = 0;
  int  pix_left_model = 0;
  bit  frame_active = 1'b0;
  int  cur_l = 1;
  int  gen_dmin = 1;
  int  gen_dmax = 1;
  int  gen_inject = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  // ---------------- generator model ----------------
  initial begin : gen
    bit held;
    bit stable;
    bit aborted;
    int d;
    forever begin
      @(negedge clk_in);
      bit_done_in = 1'b0;
      if (!rst_in && bit_rdy_out) begin
        held   = bit_data_out;
        stable = 1'b1;
        aborted = 1'b0;
        // Stale done in the request cycle must be ignored.
        if (gen_inject > 0 && $urandom_range(0, 99) < gen_inject) bit_done_in = 1'b1;
        d = $urandom_range(gen_dmax, gen_dmin);
        for (int k = 0; k < d; k++) begin
          @(negedge clk_in);
          bit_done_in = 1'b0;
          if (rst_in) begin
            aborted = 1'b1;
            break;
          end
          if (bit_data_out !== held || bit_rdy_out !== 1'b0) stable = 1'b0;
        end
        if (!aborted) begin
          check("bit_stable_until_done", stable, 1);
          if (bits_remaining == 0 && frame_active) begin
            exp_done_q.push_back(cyc + cur_l + 1);
            frame_active = 1'b0;
          end
          bit_done_in = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin
    logic [0:0] e;
    int ec;
    if (!rst_in) begin
      if (pix_ready_out) check("pix_ready_allowed", pix_left_model != 0, 1);
      if (bit_rdy_out) begin
        if (exp_q.size() == 0) check("bit_rdy_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("bit_data", bit_data_out, e);
          bits_remaining--;
          bits_seen++;
        end
      end
      if (frame_done_out) begin
        if (exp_done_q.size() == 0) check("frame_done_unexpected", 1, 0);
        else begin
          ec = exp_done_q.pop_front();
          check("frame_done_cycle", cyc, ec);
          check("busy_low_at_done", frame_busy_out, 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_frame(input int n, input int rc, input int stall_px,
                            input bit inj_start, input int abort_bit);
    int t;
    int budget;
    bit ok;
    logic [PB-1:0] data;
    @(negedge clk_in);
    t = 0;
    while (frame_busy_out && t < 1000) begin @(negedge clk_in); t++; end
    check("idle_before_start", frame_busy_out, 0);
    frame_start_in = 1'b1;
    pixel_num_in   = PW'(n);
    rst_cnt_in     = RW'(rc);
    cur_l          = (rc == 0) ? 1 : rc;
    bits_remaining = PB * n;
    bits_seen      = 0;
    pix_left_model = n;
    if (n == 0) exp_done_q.push_back(cyc + cur_l + 1);
    else frame_active = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    pixel_num_in   = PW'($urandom);
    check("busy_after_start", frame_busy_out, 1);
    for (int p = 0; p < n; p++) begin
      t = 0;
      while (!pix_ready_out && t < PB * (gen_dmax + 2) + 50) begin @(negedge clk_in); t++; end
      check("pix_ready_reached", pix_ready_out, 1);
      if (!pix_ready_out) return;
      if (p == stall_px) begin
        ok = 1'b1;
        repeat (20) begin
          if (!pix_ready_out || bit_rdy_out) ok = 1'b0;
          @(negedge clk_in);
        end
        check("stall_ready_held", ok, 1);
      end
      data = (data_q.size() != 0) ? data_q.pop_front() : PB'($urandom);
      pix_valid_in = 1'b1;
      pix_data_in  = data;
      for (int b = PB - 1; b >= 0; b--) exp_q.push_back(data[b]);
      @(negedge clk_in);
      pix_valid_in = 1'b0;
      pix_data_in  = PB'($urandom);
      pix_left_model--;
      if (inj_start && p == 0) begin
        frame_start_in = 1'b1;
        pixel_num_in   = PW'(7);
        @(negedge clk_in);
        frame_start_in = 1'b0;
      end
      if (abort_bit >= 0 && p == 1) begin
        t = 0;
        while (bits_seen < PB + abort_bit + 1 && t < PB * (gen_dmax + 2) + 50) begin
          @(negedge clk_in); t++;
        end
        check("abort_point_reached", bits_seen, PB + abort_bit + 1);
        @(posedge clk_in);
        #2 rst_in = 1'b1;
        #1 check("async_reset_outputs",
                 {pix_ready_out, bit_rdy_out, bit_data_out, frame_busy_out, frame_done_out}, 0);
        exp_q.delete();
        exp_done_q.delete();
        bits_remaining = 0;
        frame_active   = 1'b0;
        pix_left_model = 0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (30) @(negedge clk_in);
        check("no_done_after_reset", exp_done_q.size(), 0);
        return;
      end
    end
    budget = PB * n * (gen_dmax + 2) + 4 * n + cur_l + 100;
    t = 0;
    while ((frame_active || exp_done_q.size() != 0) && t < budget) begin @(negedge clk_in); t++; end
    check("frame_completed", (frame_active || exp_done_q.size() != 0), 0);
    check("bits_in_frame", bits_seen, PB * n);
    check("bit_queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (98000) @(posedge clk_in);
    $display("FAIL watchdog: cycle limit reached at cycle %0d", cyc);
    summary();
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk_in);
    check("reset_outputs",
          {pix_ready_out, bit_rdy_out, bit_data_out, frame_busy_out, frame_done_out}, 0);
    rst_in = 1'b0;

    // Single pixel, fixed generator latency.
    gen_dmin = 5; gen_dmax = 5;
    data_q.push_back(24'hA50F81);
    send_frame(1, 10, -1, 1'b0, -1);

    // Back-pressure before the second pixel.
    gen_dmin = 1; gen_dmax = 4;
    send_frame(3, 5, 1, 1'b0, -1);

    // Zero-length frame with zero gap count.
    send_frame(0, 0, -1, 1'b0, -1);

    // Ignored mid-frame start and stale done pulses.
    gen_inject = 50;
    send_frame(3, 3, -1, 1'b1, -1);
    gen_inject = 0;

    // Reset during pixel 2, bit 7, then a normal frame.
    send_frame(3, 4, -1, 1'b0, 7);
    send_frame(1, 4, -1, 1'b0, -1);

    // Randomized frames.
    gen_dmin = 1; gen_dmax = 3;
    for (int f = 0; f < 6; f++) begin
      gen_inject = $urandom_range(0, 1) * 30;
      send_frame($urandom_range(0, 4), $urandom_range(0, 12), $urandom_range(0, 5) - 1,
                 1'(($urandom_range(0, 1))), -1);
    end
    gen_inject = 0;

    // Maximum pixel count and maximum gap.
    gen_dmin = 1; gen_dmax = 1;
    send_frame(255, 65535, -1, 1'b0, -1);

    repeat (5) @(negedge clk_in);
    check("final_bit_queue_empty", exp_q.size(), 0);
    check("final_done_queue_empty", exp_done_q.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/ws2812_bit_ctl.md
Name: ws2812_bit_ctl

Overview:
Pixel-to-bit sequencer that sits directly upstream of the WS2812 bit waveform generator. It accepts 24-bit GRB pixel words over a valid/ready handshake and serialises them MSB first as one bit request per bit. It waits for the generator's per-bit done pulse before issuing the next bit. After the last bit of a frame it enforces a programmable low "latch/reset" gap, then reports frame completion.

Parameters:
PIXEL_BITS, 24, bits per pixel word; shifted out MSB first
PIX_CNT_WIDTH, 8, width of the pixels-per-frame count
RST_CNT_WIDTH, 16, width of the latch-gap cycle count

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous reset, active-high
frame_start_in  in  1  single-cycle request to start a frame
pixel_num_in  in  PIX_CNT_WIDTH  pixels in frame; sampled on accepted frame_start_in
rst_cnt_in  in  RST_CNT_WIDTH  latch-gap length in clk_in cycles; sampled on entering LATCH
pix_valid_in  in  1  pix_data_in valid
pix_data_in  in  PIXEL_BITS  pixel word, GRB, MSB sent first
pix_ready_out  out  1  block can accept a pixel word
bit_done_in  in  1  generator done pulse, one per completed bit
bit_rdy_out  out  1  one-cycle bit request to generator
bit_data_out  out  1  value of current bit; held stable from request until bit_done_in
frame_busy_out  out  1  high from accepted frame start until frame_done_out
frame_done_out  out  1  one-cycle pulse at end of latch gap

Behaviour:
- Reset is asynchronous and active-high (rst_in). Reset puts the state machine in IDLE and clears all outputs, shift register and counters to 0.
- All outputs are registered. pix_ready_out and bit_rdy_out are decoded from state registers.
- State IDLE:
  - frame_start_in=1 with pixel_num_in!=0: latch pix_left=pixel_num_in, go to LOAD, set frame_busy_out=1.
  - frame_start_in=1 with pixel_num_in==0: go straight to LATCH, frame_busy_out=1.
  - frame_start_in outside IDLE is ignored.
- State LOAD:
  - pix_ready_out=1.
  - On pix_valid_in & pix_ready_out: shift_reg<=pix_data_in, bit_idx<=PIXEL_BITS-1, go to SEND.
  - With no valid pixel, LOAD stalls indefinitely and the line idles low. Upstream must supply data within the WS2812 latch time; underrun is not detected.
- State SEND (exactly 1 cycle):
  - bit_rdy_out=1.
  - bit_data_out<=shift_reg[PIXEL_BITS-1], registered on the LOAD/WAIT->SEND transition so it is valid in the same cycle as bit_rdy_out.
  - Go to WAIT.
- State WAIT:
  - bit_rdy_out=0. bit_data_out holds its value.
  - bit_done_in arriving in the SEND cycle is ignored (stale from the previous bit).
  - On bit_done_in in WAIT:
    - bit_idx!=0: shift_reg<<=1, bit_idx-1, go to SEND.
    - bit_idx==0 and pix_left>1: pix_left-1, go to LOAD.
    - bit_idx==0 and pix_left==1: go to LATCH.
- State LATCH:
  - Load gap_cnt<=rst_cnt_in on entry. Decrement each cycle.
  - Exit when gap_cnt<=1. LATCH therefore lasts max(rst_cnt_in,1) cycles; rst_cnt_in==0 is treated as 1.
  - On exit: frame_done_out=1 for one cycle, frame_busy_out=0 in that same cycle, go to IDLE.
  - A new frame_start_in is accepted on the cycle after frame_done_out.
- Latency:
  - Pixel handshake to first bit_rdy_out: 1 cycle.
  - bit_done_in to next bit_rdy_out: 1 cycle.
  - bit_data_out is never changed while in WAIT.
- Counters are unsigned and never wrap. pixel_num_in=2^PIX_CNT_WIDTH-1 (255) sends 255 pixels.
- Reset mid-frame: immediate return to IDLE, outputs 0, no frame_done_out. Pending pixel data is discarded.

Test Plan:
- Single pixel: pixel_num_in=1, rst_cnt_in=10, pix_data_in=24'hA5_0F_81, generator model returns bit_done_in 5 cycles after each request -> 24 bit_rdy_out pulses; bit_data_out sequence 1010_0101_0000_1111_1000_0001; then 10 LATCH cycles; one frame_done_out pulse.
- Back-pressure: pixel_num_in=3, pix_valid_in held low 20 cycles before the 2nd pixel -> pix_ready_out stays high for the stall; no bit_rdy_out during the stall; 72 bits total; bit order preserved across the gap.
- Zero-length frame: pixel_num_in=0, rst_cnt_in=0 -> no pix_ready_out, no bit_rdy_out; frame_done_out exactly 2 cycles after frame_start_in (1-cycle LATCH).
- Stability and ignored starts: frame_start_in pulsed mid-frame, and bit_done_in injected during the SEND cycle -> frame_start_in ignored; no bit skipped; bit_data_out constant from each bit_rdy_out until the matching bit_done_in.
- Reset mid-frame: assert rst_in during pixel 2, bit 7 -> all outputs 0 asynchronously; no frame_done_out; a following frame with pixel_num_in=1 completes normally.
- Max count: pixel_num_in=255, rst_cnt_in=16'hFFFF -> exactly 6120 bit_rdy_out pulses; LATCH lasts 65535 cycles; single frame_done_out.
